reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Out-of-order ALU reservation station that sits directly downstream of the register file.
- Each cycle it captures at most one decoded ALU instruction together with the operand values/tags read from the register file (vj/vk/qj/qk).
- Waiting entries wake up on CDB broadcasts; one ready entry per cycle is dispatched to the ALU.
- Entries are tagged with their RoB index so ALU results return on the same CDB.

Parameters:
- RS_SIZE, 8, number of entries (power of 2).
- ROB_ADDR, 4, RoB index width; must equal the shared `RoB_addr constant.
- OP_W, 4, ALU operation code width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; one clock; reset is synchronous and active-low.
- rdy_in  input  1  global enable; when low, all state holds.
- clear_in  input  1  flush on branch mispredict; empties all entries.
- issue_valid  input  1  insert one instruction this cycle.
- issue_op  input  OP_W  ALU operation.
- issue_vj, issue_vk  input  32 each  operand values from the register file (or immediate).
- issue_qj_busy, issue_qk_busy  input  1 each  operand still pending.
- issue_qj, issue_qk  input  ROB_ADDR each  producing RoB index.
- issue_rob_id  input  ROB_ADDR  destination RoB index.
- full  output  1  no free entry.
- cdb_valid  input  1  broadcast valid.
- cdb_rob_id  input  ROB_ADDR  broadcast tag.
- cdb_value  input  32  broadcast value.
- alu_valid  output  1  dispatch valid (registered).
- alu_op  output  OP_W  dispatched operation.
- alu_v1, alu_v2  output  32 each  dispatched operands.
- alu_rob_id  output  ROB_ADDR  dispatched destination.

Behaviour:
- Per-entry state: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, rob_id.
- Update priority:
  - rst_in==0 clears all busy bits and sets alu_valid=0. All other outputs reset to 0.
  - Otherwise, when rdy_in==0 everything holds, outputs included.
  - Otherwise, when clear_in==1, all busy bits and alu_valid are cleared. Any issue or CDB input that cycle is ignored.
- full is combinational: full = (busy count == RS_SIZE). Reset/clear → full=0.
- Issue:
  - When issue_valid && !full, write into the lowest-index free entry; it becomes busy next cycle.
  - When issue_valid && full, the issue is ignored. The issuer must not do this; the bench flags it as an error.
- Issue-time bypass: if cdb_valid and cdb_rob_id matches a busy issue_qj (or issue_qk) in the same cycle, store cdb_value and clear that busy flag.
- Wakeup: every busy entry with qj_busy && qj==cdb_rob_id (or the qk equivalent) under cdb_valid captures cdb_value and clears the flag at the clock edge. Both operands may wake on the same broadcast.
- Ready = busy && !qj_busy && !qk_busy, evaluated on registered state.
  - An entry woken or issued this cycle is not eligible until the next cycle.
- Dispatch:
  - Select the lowest-index ready entry.
  - Next edge: alu_valid=1, alu_* = that entry's fields, and the entry's busy bit is cleared.
  - If none is ready, alu_valid=0 and the other alu_* outputs hold their previous values.
  - Latency: an operand-ready issue at cycle N → alu_valid at edge N+2 (captured at N+1, dispatched N+1→N+2).
- Issue and dispatch in the same cycle are allowed. A slot freed by dispatch is reusable from the next cycle; full does not anticipate the free.
- No ALU backpressure: the ALU accepts one op per cycle.
- Tags wrap modulo 2^ROB_ADDR. Uniqueness of in-flight tags is guaranteed by the RoB.

Decomposition:
- Shared const.v holds `RoB_addr, RS_SIZE, the ALU op encodings and OP_W.
- One sub-module: rs_select, a combinational lowest-index priority encoder. It takes a RS_SIZE-bit vector and returns index plus found. It is reused for free-slot search and ready-entry search.

Test Plan:
- Reset/basic:
  - Stimulus: rst_in low 2 cycles, then issue op=ADD, vj=5, vk=7, both not busy, rob=3.
  - Response: full=0 after reset; alu_valid high exactly 2 edges later with v1=5, v2=7, rob_id=3; entry freed.
- Wakeup:
  - Stimulus: issue with qj_busy, qj=6, vk=1. Two cycles later CDB rob=6, value=0x10.
  - Response: no dispatch before the broadcast; dispatch one cycle after the broadcast with v1=0x10, v2=1.
- Issue-time bypass:
  - Stimulus: issue qk_busy, qk=2 in the same cycle as CDB rob=2, value=0xAA.
  - Response: entry stored ready; dispatch at issue+2 with v2=0xAA.
- Fill/full:
  - Stimulus: issue 8 entries all waiting on tag 9.
  - Response: full=1. A 9th issue is ignored. CDB tag 9 wakes all entries; they dispatch in index order over 8 consecutive cycles; full drops the cycle after the first dispatch.
- Flush:
  - Stimulus: 5 busy entries, then assert clear_in alongside issue_valid and a matching CDB.
  - Response: count=0, alu_valid=0 next cycle; no later dispatch from flushed tags.
- Stall:
  - Stimulus: hold rdy_in low for 3 cycles while a ready entry exists and the CDB fires.
  - Response: state and outputs frozen; the CDB is ignored; dispatch resumes after rdy_in returns.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared constants, ALU op encodings and the entry record for the ALU reservation station.
package reservation_station_pkg;

    localparam int RS_SIZE  = 8;
    localparam int ROB_ADDR = 4;
    localparam int OP_W     = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [DATA_W-1:0]   vj;
        logic [DATA_W-1:0]   vk;
        logic                qj_busy;
        logic                qk_busy;
        logic [ROB_ADDR-1:0] qj;
        logic [ROB_ADDR-1:0] qk;
        logic [ROB_ADDR-1:0] rob_id;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and ALU-dispatch bundle around the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                issue_valid;
    logic [OP_W-1:0]     issue_op;
    logic [DATA_W-1:0]   issue_vj;
    logic [DATA_W-1:0]   issue_vk;
    logic                issue_qj_busy;
    logic                issue_qk_busy;
    logic [ROB_ADDR-1:0] issue_qj;
    logic [ROB_ADDR-1:0] issue_qk;
    logic [ROB_ADDR-1:0] issue_rob_id;
    logic                full;

    logic                cdb_valid;
    logic [ROB_ADDR-1:0] cdb_rob_id;
    logic [DATA_W-1:0]   cdb_value;

    logic                alu_valid;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_v1;
    logic [DATA_W-1:0]   alu_v2;
    logic [ROB_ADDR-1:0] alu_rob_id;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
               cdb_valid, cdb_rob_id, cdb_value,
        input  full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
               cdb_valid, cdb_rob_id, cdb_value,
        output full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
    );

endinterface

// File: rtl/reservation_station_rs_select.sv
// Combinational lowest-index priority encoder used for free-slot and ready-entry search.
module reservation_station_rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order ALU reservation station: captures issued ops, wakes them on CDB, dispatches one per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    reservation_station_if.slave io
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready_vec;
    rs_entry_t          ent [RS_SIZE];
    rs_entry_t          new_ent;

    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   rdy_idx;
    logic               free_found;
    logic               rdy_found;
    logic               accept;

    logic                vld_p1;
    logic [OP_W-1:0]     op_p1;
    logic [DATA_W-1:0]   v1_p1;
    logic [DATA_W-1:0]   v2_p1;
    logic [ROB_ADDR-1:0] rob_p1;

    function automatic logic cdb_hit(input logic                pend,
                                     input logic [ROB_ADDR-1:0] tag,
                                     input logic                cv,
                                     input logic [ROB_ADDR-1:0] ct);
        return pend && cv && (tag == ct);
    endfunction

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & ~ent[i].qj_busy & ~ent[i].qk_busy;
        end
    end

    reservation_station_rs_select #(.N(RS_SIZE)) u_free_sel (
        .vec   (~busy),
        .idx   (free_idx),
        .found (free_found)
    );

    reservation_station_rs_select #(.N(RS_SIZE)) u_rdy_sel (
        .vec   (ready_vec),
        .idx   (rdy_idx),
        .found (rdy_found)
    );

    assign io.full = &busy;
    assign accept  = io.issue_valid && !io.full && free_found;

    // A broadcast in the issue cycle would otherwise be missed, since the entry is not busy yet.
    always_comb begin
        new_ent.op      = io.issue_op;
        new_ent.vj      = io.issue_vj;
        new_ent.vk      = io.issue_vk;
        new_ent.qj_busy = io.issue_qj_busy;
        new_ent.qk_busy = io.issue_qk_busy;
        new_ent.qj      = io.issue_qj;
        new_ent.qk      = io.issue_qk;
        new_ent.rob_id  = io.issue_rob_id;
        if (cdb_hit(io.issue_qj_busy, io.issue_qj, io.cdb_valid, io.cdb_rob_id)) begin
            new_ent.vj      = io.cdb_value;
            new_ent.qj_busy = 1'b0;
        end
        if (cdb_hit(io.issue_qk_busy, io.issue_qk, io.cdb_valid, io.cdb_rob_id)) begin
            new_ent.vk      = io.cdb_value;
            new_ent.qk_busy = 1'b0;
        end
    end

    // Stage p0 -> p1: entry update, wakeup and dispatch register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy   <= '0;
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            v1_p1  <= '0;
            v2_p1  <= '0;
            rob_p1 <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy   <= '0;
                vld_p1 <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && cdb_hit(ent[i].qj_busy, ent[i].qj, io.cdb_valid, io.cdb_rob_id)) begin
                        ent[i].vj      <= io.cdb_value;
                        ent[i].qj_busy <= 1'b0;
                    end
                    if (busy[i] && cdb_hit(ent[i].qk_busy, ent[i].qk, io.cdb_valid, io.cdb_rob_id)) begin
                        ent[i].vk      <= io.cdb_value;
                        ent[i].qk_busy <= 1'b0;
                    end
                end

                if (rdy_found) begin
                    vld_p1        <= 1'b1;
                    op_p1         <= ent[rdy_idx].op;
                    v1_p1         <= ent[rdy_idx].vj;
                    v2_p1         <= ent[rdy_idx].vk;
                    rob_p1        <= ent[rdy_idx].rob_id;
                    busy[rdy_idx] <= 1'b0;
                end else begin
                    vld_p1 <= 1'b0;
                end

                // The free slot is never the dispatching one, so these writes cannot collide.
                if (accept) begin
                    busy[free_idx] <= 1'b1;
                    ent[free_idx]  <= new_ent;
                end
            end
        end
    end

    assign io.alu_valid  = vld_p1;
    assign io.alu_op     = op_p1;
    assign io.alu_v1     = v1_p1;
    assign io.alu_v2     = v2_p1;
    assign io.alu_rob_id = rob_p1;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for the reservation station: reset, dispatch latency, wakeup, bypass, fill, flush, stall.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear_in;
    int   checks;
    int   failures;

    reservation_station_if bus ();

    reservation_station dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .io       (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        clear_in        = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [3:0] qj,
                         input logic qkb, input logic [3:0] qk, input logic [3:0] rob);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_vk      = vk;
        bus.issue_qj_busy = qjb;
        bus.issue_qj      = qj;
        bus.issue_qk_busy = qkb;
        bus.issue_qk      = qk;
        bus.issue_rob_id  = rob;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid  = 1'b1;
        bus.cdb_rob_id = tag;
        bus.cdb_value  = val;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        bus.issue_op = '0; bus.issue_vj = '0; bus.issue_vk = '0;
        bus.issue_qj_busy = 1'b0; bus.issue_qk_busy = 1'b0;
        bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_rob_id = '0;
        bus.cdb_rob_id = '0; bus.cdb_value = '0;
        idle();

        // Reset
        tick(); tick();
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_valid", 32'(bus.alu_valid), 32'd0);
        chk("rst_v1", bus.alu_v1, 32'd0);
        chk("rst_rob", 32'(bus.alu_rob_id), 32'd0);
        rst_in = 1'b1;

        // Basic issue with both operands ready: dispatch two edges later
        issue(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick(); idle();
        chk("basic_no_early", 32'(bus.alu_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(bus.alu_valid), 32'd1);
        chk("basic_op", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("basic_v1", bus.alu_v1, 32'd5);
        chk("basic_v2", bus.alu_v2, 32'd7);
        chk("basic_rob", 32'(bus.alu_rob_id), 32'd3);
        tick();
        chk("basic_freed", 32'(bus.alu_valid), 32'd0);
        chk("basic_hold_v1", bus.alu_v1, 32'd5);

        // Wakeup from CDB
        issue(ALU_SUB, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
        tick(); idle();
        chk("wake_wait0", 32'(bus.alu_valid), 32'd0);
        tick();
        chk("wake_wait1", 32'(bus.alu_valid), 32'd0);
        cdb(4'd6, 32'h10);
        tick(); idle();
        chk("wake_not_same", 32'(bus.alu_valid), 32'd0);
        tick();
        chk("wake_valid", 32'(bus.alu_valid), 32'd1);
        chk("wake_v1", bus.alu_v1, 32'h10);
        chk("wake_v2", bus.alu_v2, 32'd1);
        chk("wake_rob", 32'(bus.alu_rob_id), 32'd4);
        tick();

        // Issue-time bypass
        issue(ALU_AND, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd5);
        cdb(4'd2, 32'hAA);
        tick(); idle();
        chk("byp_no_early", 32'(bus.alu_valid), 32'd0);
        tick();
        chk("byp_valid", 32'(bus.alu_valid), 32'd1);
        chk("byp_v1", bus.alu_v1, 32'd3);
        chk("byp_v2", bus.alu_v2, 32'hAA);
        chk("byp_rob", 32'(bus.alu_rob_id), 32'd5);
        tick();

        // Fill all entries waiting on tag 9
        for (int i = 0; i < 8; i++) begin
            issue(ALU_OR, 32'd0, 32'(100 + i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle();
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_no_disp", 32'(bus.alu_valid), 32'd0);
        issue(ALU_XOR, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        tick(); idle();
        chk("fill_full_hold", 32'(bus.full), 32'd1);
        chk("fill_ovf_ignored", 32'(bus.alu_valid), 32'd0);
        cdb(4'd9, 32'h99);
        tick(); idle();
        chk("fill_wake_no_disp", 32'(bus.alu_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fill_valid", 32'(bus.alu_valid), 32'd1);
            chk("fill_rob", 32'(bus.alu_rob_id), 32'(k));
            chk("fill_v1", bus.alu_v1, 32'h99);
            chk("fill_v2", bus.alu_v2, 32'(100 + k));
            if (k == 0) chk("fill_full_drop", 32'(bus.full), 32'd0);
        end
        tick();
        chk("fill_drained", 32'(bus.alu_valid), 32'd0);

        // Flush: four waiting entries plus one ready entry that would dispatch on the clear edge
        for (int i = 0; i < 4; i++) begin
            issue(ALU_SLL, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
            tick();
        end
        issue(ALU_SRL, 32'h44, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        tick();
        issue(ALU_ADD, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        cdb(4'd12, 32'hCC);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        bus.issue_valid = 1'b0;
        chk("flush_valid", 32'(bus.alu_valid), 32'd0);
        chk("flush_full", 32'(bus.full), 32'd0);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_disp", 32'(bus.alu_valid), 32'd0);
            tick();
        end

        // Stall: freeze with alu_valid high, a ready entry queued and a CDB firing
        issue(ALU_SRA, 32'd0, 32'd5, 1'b1, 4'd13, 1'b0, 4'd0, 4'd9);
        tick();
        issue(ALU_SLT, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        tick();
        issue(ALU_SLTU, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        tick(); idle();
        chk("stall_pre_valid", 32'(bus.alu_valid), 32'd1);
        chk("stall_pre_rob", 32'(bus.alu_rob_id), 32'd8);
        rdy_in = 1'b0;
        cdb(4'd13, 32'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(bus.alu_valid), 32'd1);
            chk("stall_rob", 32'(bus.alu_rob_id), 32'd8);
            chk("stall_v1", bus.alu_v1, 32'h11);
        end
        rdy_in = 1'b1;
        idle();
        tick();
        chk("resume_valid", 32'(bus.alu_valid), 32'd1);
        chk("resume_rob", 32'(bus.alu_rob_id), 32'd10);
        chk("resume_v1", bus.alu_v1, 32'h33);
        tick();
        chk("stall_cdb_ignored", 32'(bus.alu_valid), 32'd0);
        cdb(4'd13, 32'h77);
        tick(); idle();
        tick();
        chk("late_wake_valid", 32'(bus.alu_valid), 32'd1);
        chk("late_wake_rob", 32'(bus.alu_rob_id), 32'd9);
        chk("late_wake_v1", bus.alu_v1, 32'h77);
        chk("late_wake_v2", bus.alu_v2, 32'd5);
        tick();
        chk("end_idle", 32'(bus.alu_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
